// File: rtl/snake_pkg.sv
// Shared definitions for the snake datapath: packed-location layout, direction and
// state encodings, playfield defaults, and pack/unpack helpers.
package snake_pkg;

    localparam int LOC_W   = 40;
    localparam int FLD_W   = 10;
    localparam int W_LSB   = 30;
    localparam int H_LSB   = 20;
    localparam int X_LSB   = 10;
    localparam int Y_LSB   = 0;

    localparam int STEP_DEF    = 16;
    localparam int FIELD_W_DEF = 640;
    localparam int FIELD_H_DEF = 480;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    typedef struct packed {
        logic [FLD_W-1:0] x;
        logic [FLD_W-1:0] y;
    } pt_t;

    // Opposite pairs differ only in bit 0 of the encoding.
    function automatic dir_e dir_opp(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    function automatic logic [LOC_W-1:0] loc_pack(input logic [FLD_W-1:0] w,
                                                  input logic [FLD_W-1:0] h,
                                                  input logic [FLD_W-1:0] x,
                                                  input logic [FLD_W-1:0] y);
        return {w, h, x, y};
    endfunction

    function automatic pt_t loc_unpack(input logic [LOC_W-1:0] loc);
        pt_t p;
        p.x = loc[X_LSB +: FLD_W];
        p.y = loc[Y_LSB +: FLD_W];
        return p;
    endfunction

endpackage

// File: rtl/snake_seg_buf.sv
// Segment shift register holding the snake body (segment 0 = head), with a parallel
// compare against a candidate point and a registered random-access read port.
module snake_seg_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int STEP    = STEP_DEF,
    parameter int INIT_X  = 256,
    parameter int INIT_Y  = 224
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_init,
    input  logic               shift_en,
    input  pt_t                new_head,
    input  pt_t                cmp_pt,
    output logic [MAX_LEN-1:0] match,
    input  logic [4:0]         rd_idx,
    input  logic [5:0]         length,
    output logic [LOC_W-1:0]   rd_loc,
    output logic               rd_valid
);

    pt_t              seg_q [MAX_LEN];
    pt_t              seg_d [MAX_LEN];
    logic [LOC_W-1:0] rd_loc_d;
    logic             rd_valid_d;
    pt_t              rd_pt;
    logic             rd_hit;

    // Start layout: a horizontal line trailing left of the head.
    function automatic pt_t init_seg(input int k);
        pt_t p;
        p.x = FLD_W'(INIT_X - STEP * k);
        p.y = FLD_W'(INIT_Y);
        return p;
    endfunction

    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            seg_d[k] = seg_q[k];
        end
        if (load_init) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_d[k] = init_seg(k);
            end
        end else if (shift_en) begin
            seg_d[0] = new_head;
            for (int k = 1; k < MAX_LEN; k++) begin
                seg_d[k] = seg_q[k-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            match[k] = (seg_q[k] == cmp_pt);
        end
    end

    always_comb begin
        rd_pt  = '0;
        rd_hit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (rd_idx == 5'(k)) begin
                rd_pt  = seg_q[k];
                rd_hit = 1'b1;
            end
        end
        rd_loc_d   = rd_hit ? loc_pack(FLD_W'(STEP), FLD_W'(STEP), rd_pt.x, rd_pt.y) : '0;
        rd_valid_d = ({1'b0, rd_idx} < length);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_q[k] <= init_seg(k);
            end
            rd_loc   <= '0;
            rd_valid <= 1'b0;
        end else begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_q[k] <= seg_d[k];
            end
            rd_loc   <= rd_loc_d;
            rd_valid <= rd_valid_d;
        end
    end

endmodule

// File: rtl/snake_body.sv
// Snake head/body controller: IDLE/RUN/DEAD FSM, direction, grow and collision logic.
// Define SNAKE_WALL_WRAP_EN to wrap at the playfield edges instead of dying.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int STEP     = STEP_DEF,
    parameter int FIELD_W  = FIELD_W_DEF,
    parameter int FIELD_H  = FIELD_H_DEF,
    parameter int INIT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic             start,
    input  logic [3:0]       btn,
    input  logic             overlap,
    output logic [LOC_W-1:0] snakehead,
    input  logic [4:0]       seg_idx,
    output logic [LOC_W-1:0] seg_location,
    output logic             seg_valid,
    output logic [4:0]       length,
    output logic             game_over
);

    localparam int INIT_X = 256;
    localparam int INIT_Y = 224;
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_MAX  = 11'(FIELD_W - STEP);
    localparam logic signed [10:0] Y_MAX  = 11'(FIELD_H - STEP);
    localparam pt_t INIT_PT = '{x: FLD_W'(INIT_X), y: FLD_W'(INIT_Y)};

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    dir_e   last_dir_q, last_dir_d;
    logic   grow_q, grow_d;
    logic   go_q, go_d;
    logic [5:0] len_q, len_d;
    pt_t    head_q, head_d;

    dir_e   btn_dir;
    dir_e   ref_dir;
    logic   signed [10:0] nx_raw, ny_raw, nx, ny;
    logic   wall;
    pt_t    next_pt;
    logic   grow_eff;
    logic   [5:0] cmp_lim;
    logic   [MAX_LEN-1:0] match;
    logic   [MAX_LEN-1:0] live_mask;
    logic   self_hit;
    logic   collide;
    logic   move;
    logic   load_init;

    always_comb begin
        nx_raw = $signed({1'b0, head_q.x});
        ny_raw = $signed({1'b0, head_q.y});
        case (dir_q)
            DIR_UP:    ny_raw = ny_raw - STEP_S;
            DIR_DOWN:  ny_raw = ny_raw + STEP_S;
            DIR_LEFT:  nx_raw = nx_raw - STEP_S;
            default:   nx_raw = nx_raw + STEP_S;
        endcase
`ifdef SNAKE_WALL_WRAP_EN
        nx   = (nx_raw < 11'sd0) ? X_MAX : ((nx_raw > X_MAX) ? 11'sd0 : nx_raw);
        ny   = (ny_raw < 11'sd0) ? Y_MAX : ((ny_raw > Y_MAX) ? 11'sd0 : ny_raw);
        wall = 1'b0;
`else
        nx   = nx_raw;
        ny   = ny_raw;
        wall = (nx_raw < 11'sd0) || (nx_raw > X_MAX) || (ny_raw < 11'sd0) || (ny_raw > Y_MAX);
`endif
        next_pt = '{x: nx[9:0], y: ny[9:0]};
    end

    // When growing the tail stays put, so it must be included in the self check.
    always_comb begin
        grow_eff = grow_q && (len_q < 6'(MAX_LEN));
        cmp_lim  = grow_eff ? len_q : 6'(len_q - 6'd1);
        for (int k = 0; k < MAX_LEN; k++) begin
            live_mask[k] = (6'(k) < cmp_lim);
        end
        self_hit = |(match & live_mask);
        collide  = wall || self_hit;
        move     = (state_q == ST_RUN) && update && !collide;
    end

    always_comb begin
        if (btn[3])      btn_dir = DIR_UP;
        else if (btn[2]) btn_dir = DIR_DOWN;
        else if (btn[1]) btn_dir = DIR_LEFT;
        else             btn_dir = DIR_RIGHT;
        // Reversal is judged against the direction committed by the most recent move.
        ref_dir = move ? dir_q : last_dir_q;
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        grow_d     = grow_q | overlap;
        go_d       = go_q;
        len_d      = len_q;
        head_d     = head_q;
        load_init  = 1'b0;

        if ((|btn) && (btn_dir != dir_opp(ref_dir))) begin
            dir_d = btn_dir;
        end

        case (state_q)
            ST_IDLE, ST_DEAD: begin
                if (update && start) begin
                    state_d    = ST_RUN;
                    head_d     = INIT_PT;
                    len_d      = 6'(INIT_LEN);
                    dir_d      = DIR_RIGHT;
                    last_dir_d = DIR_RIGHT;
                    grow_d     = 1'b0;
                    go_d       = 1'b0;
                    load_init  = 1'b1;
                end
            end
            ST_RUN: begin
                if (update) begin
                    if (collide) begin
                        state_d = ST_DEAD;
                        go_d    = 1'b1;
                    end else begin
                        head_d     = next_pt;
                        last_dir_d = dir_q;
                        grow_d     = overlap;
                        if (grow_eff) begin
                            len_d = len_q + 6'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            last_dir_q <= DIR_RIGHT;
            grow_q     <= 1'b0;
            go_q       <= 1'b0;
            len_q      <= 6'(INIT_LEN);
            head_q     <= INIT_PT;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            grow_q     <= grow_d;
            go_q       <= go_d;
            len_q      <= len_d;
            head_q     <= head_d;
        end
    end

    snake_seg_buf #(
        .MAX_LEN (MAX_LEN),
        .STEP    (STEP),
        .INIT_X  (INIT_X),
        .INIT_Y  (INIT_Y)
    ) u_seg_buf (
        .clk       (clk),
        .rst       (rst),
        .load_init (load_init),
        .shift_en  (move),
        .new_head  (next_pt),
        .cmp_pt    (next_pt),
        .match     (match),
        .rd_idx    (seg_idx),
        .length    (len_q),
        .rd_loc    (seg_location),
        .rd_valid  (seg_valid)
    );

    // A length of 32 (MAX_LEN=32) does not fit the 5-bit port and reads back as 0.
    assign snakehead = loc_pack(FLD_W'(STEP), FLD_W'(STEP), head_q.x, head_q.y);
    assign length    = len_q[4:0];
    assign game_over = go_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: drivers push expected head/length/game_over and
// segment reads into queues; a negedge monitor pops and compares them.
module tb_snake_body;
    import snake_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        update = 1'b0;
    logic        start = 1'b0;
    logic        overlap = 1'b0;
    logic [3:0]  btn = 4'b0000;
    logic [4:0]  seg_idx = 5'd0;
    logic [39:0] snakehead;
    logic [39:0] seg_location;
    logic        seg_valid;
    logic [4:0]  length;
    logic        game_over;

    logic        probe = 1'b0;
    logic        rd_req = 1'b0;
    logic        upd_d1 = 1'b0;
    logic        probe_d1 = 1'b0;
    logic        rd_d1 = 1'b0;

    logic [45:0] exp_q[$];
    string       name_q[$];
    logic [40:0] seg_q[$];
    string       seg_name_q[$];

    int errors = 0;
    int checks = 0;

    logic [45:0] mon_e;
    logic [40:0] mon_s;
    string       mon_n;

    snake_body dut (
        .clk          (clk),
        .rst          (rst),
        .update       (update),
        .start        (start),
        .btn          (btn),
        .overlap      (overlap),
        .snakehead    (snakehead),
        .seg_idx      (seg_idx),
        .seg_location (seg_location),
        .seg_valid    (seg_valid),
        .length       (length),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected-state words are {snakehead, length, game_over}.
    always @(posedge clk) begin
        upd_d1   <= update;
        probe_d1 <= probe;
        rd_d1    <= rd_req;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (upd_d1 || probe_d1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL state_queue_empty: got empty expected entry");
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_n = name_q.pop_front();
                    cmp(mon_n, {18'd0, snakehead, length, game_over}, {18'd0, mon_e});
                end
            end
            if (rd_d1) begin
                if (seg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seg_queue_empty: got empty expected entry");
                end else begin
                    mon_s = seg_q.pop_front();
                    mon_n = seg_name_q.pop_front();
                    if (mon_s[40]) cmp(mon_n, {23'd0, seg_location, seg_valid}, {23'd0, mon_s[39:0], 1'b1});
                    else           cmp(mon_n, {63'd0, seg_valid}, 64'd0);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [45:0] exp_word(input int ex, input int ey, input int el, input logic eg);
        return {loc_pack(10'd16, 10'd16, 10'(ex), 10'(ey)), 5'(el), eg};
    endfunction

    task automatic upd(input string nm, input logic s, input int ex, input int ey,
                       input int el, input logic eg);
        start  = s;
        update = 1'b1;
        exp_q.push_back(exp_word(ex, ey, el, eg));
        name_q.push_back(nm);
        cyc(1);
        update = 1'b0;
        start  = 1'b0;
        cyc(1);
    endtask

    task automatic probe_chk(input string nm, input int ex, input int ey, input int el, input logic eg);
        probe = 1'b1;
        exp_q.push_back(exp_word(ex, ey, el, eg));
        name_q.push_back(nm);
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic rd(input string nm, input int idx, input int ex, input int ey, input logic v);
        seg_idx = 5'(idx);
        rd_req  = 1'b1;
        seg_q.push_back({v, loc_pack(10'd16, 10'd16, 10'(ex), 10'(ey))});
        seg_name_q.push_back(nm);
        cyc(1);
        rd_req = 1'b0;
    endtask

    task automatic steer(input logic [3:0] b);
        btn = b;
        cyc(1);
    endtask

    task automatic eat();
        overlap = 1'b1;
        cyc(1);
        overlap = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cmp("rst_seg_valid", {63'd0, seg_valid}, 64'd0);
        cmp("rst_seg_loc", {24'd0, seg_location}, 64'd0);
        probe_chk("reset_state", 256, 224, 3, 1'b0);
        rd("rst_seg2", 2, 224, 224, 1'b1);
        rd("rst_seg3_invalid", 3, 0, 0, 1'b0);

        upd("start", 1'b1, 256, 224, 3, 1'b0);
        eat();
        upd("grow_move", 1'b0, 272, 224, 4, 1'b0);
        rd("seg3_kept", 3, 224, 224, 1'b1);
        rd("seg4_invalid", 4, 0, 0, 1'b0);
        upd("move_r1", 1'b0, 288, 224, 4, 1'b0);
        upd("move_r2", 1'b0, 304, 224, 4, 1'b0);

        steer(4'b0010);
        upd("reverse_ignored", 1'b0, 320, 224, 4, 1'b0);
        steer(4'b1010);
        upd("up_priority", 1'b0, 320, 208, 4, 1'b0);

        steer(4'b0001);
        for (int i = 1; i <= 19; i++) begin
            upd("run_right", 1'b0, 320 + 16 * i, 208, 4, 1'b0);
        end
`ifdef SNAKE_WALL_WRAP_EN
        upd("wall_wrap", 1'b0, 0, 208, 4, 1'b0);
        upd("start_ignored_run", 1'b1, 16, 208, 4, 1'b0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
`else
        upd("wall_hit", 1'b0, 624, 208, 4, 1'b1);
        upd("dead_hold", 1'b0, 624, 208, 4, 1'b1);
`endif
        steer(4'b0000);
        upd("restart", 1'b1, 256, 224, 3, 1'b0);

        eat();
        upd("len5_g4", 1'b0, 272, 224, 4, 1'b0);
        eat();
        upd("len5_g5", 1'b0, 288, 224, 5, 1'b0);
        upd("len5_right", 1'b0, 304, 224, 5, 1'b0);
        steer(4'b0100);
        upd("len5_down", 1'b0, 304, 240, 5, 1'b0);
        steer(4'b0010);
        upd("len5_left", 1'b0, 288, 240, 5, 1'b0);
        steer(4'b1000);
        upd("self_hit", 1'b0, 288, 240, 5, 1'b1);

        steer(4'b0000);
        upd("restart2", 1'b1, 256, 224, 3, 1'b0);
        eat();
        upd("len4_g4", 1'b0, 272, 224, 4, 1'b0);
        upd("len4_right", 1'b0, 288, 224, 4, 1'b0);
        steer(4'b0100);
        upd("len4_down", 1'b0, 288, 240, 4, 1'b0);
        steer(4'b0010);
        upd("len4_left", 1'b0, 272, 240, 4, 1'b0);
        steer(4'b1000);
        upd("tail_vacates", 1'b0, 272, 224, 4, 1'b0);

        eat();
        upd("len7_g5", 1'b0, 272, 208, 5, 1'b0);
        eat();
        upd("len7_g6", 1'b0, 272, 192, 6, 1'b0);
        eat();
        upd("len7_g7", 1'b0, 272, 176, 7, 1'b0);

        rst = 1'b1;
        #1;
        cmp("midrst_head", {24'd0, snakehead}, {24'd0, loc_pack(10'd16, 10'd16, 10'd256, 10'd224)});
        cmp("midrst_len", {59'd0, length}, 64'd3);
        cmp("midrst_game_over", {63'd0, game_over}, 64'd0);
        cyc(2);
        rst = 1'b0;
        rd("midrst_seg2", 2, 224, 224, 1'b1);

        steer(4'b0000);
        upd("start3", 1'b1, 256, 224, 3, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            eat();
            upd("saturate", 1'b0, 256 + 16 * i, 224, (3 + i > 16) ? 16 : 3 + i, 1'b0);
        end
        rd("sat_tail15", 15, 240, 224, 1'b1);
        rd("sat_idx16_invalid", 16, 0, 0, 1'b0);

        cyc(3);
        cmp("state_queue_drained", 64'(exp_q.size()), 64'd0);
        cmp("seg_queue_drained", 64'(seg_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
